// File: rtl/matdet_pkg.sv
// Shared types and tables for the sequential determinant engine.
// FSM states, size encodings, column-pair table and combine signs.
package matdet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MTOP,
    S_MBOT,
    S_COMB,
    S_DONE
  } state_t;

  localparam logic [1:0] N2   = 2'd0;
  localparam logic [1:0] N3   = 2'd1;
  localparam logic [1:0] N4   = 2'd2;
  localparam logic [1:0] NILL = 2'd3;

  localparam logic [4:0] MACS_N2 = 5'd2;
  localparam logic [4:0] MACS_N3 = 5'd9;
  localparam logic [4:0] MACS_N4 = 5'd30;

  // MACs spent building one bank of minors
  localparam logic [4:0] MIN3_OPS = 5'd6;
  localparam logic [4:0] MIN4_OPS = 5'd12;

  // bit p set: term p of the 4x4 combine is subtracted
  localparam logic [5:0] COMB_NEG = 6'b010010;

  // column pairs 01,02,03,12,13,23
  function automatic logic [1:0] pair_lo(
    input logic [2:0] p
  );
    unique case (p)
      3'd0, 3'd1, 3'd2: pair_lo = 2'd0;
      3'd3, 3'd4:       pair_lo = 2'd1;
      default:          pair_lo = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pair_hi(
    input logic [2:0] p
  );
    unique case (p)
      3'd0:       pair_hi = 2'd1;
      3'd1, 3'd3: pair_hi = 2'd2;
      default:    pair_hi = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/matdet_seq_fxp_mac.sv
// Combinational fixed-point multiply-accumulate step.
// x,y,acc_in,subtract,clear in; acc_out = base +/- (x*y)>>>FRAC_BITS.
module fxp_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic                  subtract,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] acc_out
);

  localparam int DW = DATA_WIDTH;

  logic signed [2*DW-1:0] xs;
  logic signed [2*DW-1:0] ys;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0] term;
  logic [DW-1:0] base;

  always_comb begin
    xs   = {{DW{x[DW-1]}}, x};
    ys   = {{DW{y[DW-1]}}, y};
    prod = xs * ys;
    term = DW'(prod >>> FRAC_BITS);
    base = clear ? '0 : acc_in;
    acc_out = subtract ? base - term
                       : base + term;
  end

endmodule

// File: rtl/matdet_seq.sv
// Time-shared determinant engine for 2x2/3x3/4x4 signed matrices.
// in_valid/in_ready/n_sel/mat in; out_valid/out_ready/det/err out.
module matdet_seq
  import matdet_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               n_sel,
  input  logic [16*DATA_WIDTH-1:0] mat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    det,
  output logic                     err
);

  localparam int DW = DATA_WIDTH;

  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] nsel_q;
  logic       err_q;
  logic [DW-1:0] mat_q [16];
  logic [DW-1:0] top_q [6];
  logic [DW-1:0] bot_q [6];
  logic [DW-1:0] acc_q;
  logic [DW-1:0] det_q;

  logic [2:0] k;
  logic [2:0] j;
  logic [2:0] jb;
  logic [2:0] pidx;
  logic [1:0] r0, r1, cl, ch;
  logic [DW-1:0] x, y, acc_out;
  logic sub, clr, mac_en, last;
  logic wr_top, wr_bot, accept;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign det       = det_q;
  assign err       = err_q;

  // minor index advances every second op
  assign k  = cnt_q[3:1];
  assign j  = cnt_q[2:0];
  assign jb = 3'd5 - j;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x       = '0;
    y       = '0;
    sub     = 1'b0;
    clr     = 1'b0;
    mac_en  = 1'b0;
    last    = 1'b0;
    wr_top  = 1'b0;
    wr_bot  = 1'b0;
    r0      = 2'd0;
    r1      = 2'd1;
    pidx    = 3'd0;
    cl      = 2'd0;
    ch      = 2'd1;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cnt_d = 5'd0;
          if (n_sel == N2 || n_sel == NILL)
            state_d = S_COMB;
          else
            state_d = S_MTOP;
        end
      end
      S_MTOP, S_MBOT: begin
        mac_en = 1'b1;
        sub    = cnt_q[0];
        clr    = ~cnt_q[0];
        if (state_q == S_MBOT) begin
          r0     = 2'd2;
          r1     = 2'd3;
          pidx   = k;
          wr_bot = cnt_q[0];
          last   = (cnt_q == MIN4_OPS - 5'd1);
        end else if (nsel_q == N3) begin
          // 3x3 cofactor order: pairs 12, 02, 01
          r0     = 2'd1;
          r1     = 2'd2;
          pidx   = (k == 3'd0) ? 3'd3 :
                   (k == 3'd1) ? 3'd1 : 3'd0;
          wr_top = cnt_q[0];
          last   = (cnt_q == MIN3_OPS - 5'd1);
        end else begin
          r0     = 2'd0;
          r1     = 2'd1;
          pidx   = k;
          wr_top = cnt_q[0];
          last   = (cnt_q == MIN4_OPS - 5'd1);
        end
        cl = pair_lo(pidx);
        ch = pair_hi(pidx);
        x  = sub ? mat_q[{r0, ch}] : mat_q[{r0, cl}];
        y  = sub ? mat_q[{r1, cl}] : mat_q[{r1, ch}];
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          cnt_d = 5'd0;
          if (state_q == S_MTOP && nsel_q == N4)
            state_d = S_MBOT;
          else
            state_d = S_COMB;
        end
      end
      S_COMB: begin
        clr    = (j == 3'd0);
        mac_en = (nsel_q != NILL);
        unique case (nsel_q)
          N2: begin
            sub  = cnt_q[0];
            x    = sub ? mat_q[4'd1] : mat_q[4'd0];
            y    = sub ? mat_q[4'd4] : mat_q[4'd5];
            last = (cnt_q == MACS_N2 - 5'd1);
          end
          N3: begin
            sub  = (j == 3'd1);
            x    = mat_q[{2'd0, j[1:0]}];
            y    = top_q[j];
            last = (cnt_q == MACS_N3 - MIN3_OPS - 5'd1);
          end
          N4: begin
            sub  = COMB_NEG[j];
            x    = top_q[j];
            y    = bot_q[jb];
            last = (cnt_q == MACS_N4 - 5'd2 * MIN4_OPS - 5'd1);
          end
          NILL: last = 1'b1;
        endcase
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          cnt_d   = 5'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  fxp_mac #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .x       (x),
    .y       (y),
    .acc_in  (acc_q),
    .subtract(sub),
    .clear   (clr),
    .acc_out (acc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      nsel_q  <= N2;
      err_q   <= 1'b0;
      acc_q   <= '0;
      det_q   <= '0;
      for (int i = 0; i < 16; i++) mat_q[i] <= '0;
      for (int i = 0; i < 6; i++) begin
        top_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        nsel_q <= n_sel;
        err_q  <= (n_sel == NILL);
        for (int i = 0; i < 16; i++)
          mat_q[i] <= mat[i*DW +: DW];
      end
      if (mac_en) acc_q <= acc_out;
      if (wr_top) top_q[k] <= acc_out;
      if (wr_bot) bot_q[k] <= acc_out;
      if (state_q == S_COMB && last)
        det_q <= mac_en ? acc_out : '0;
    end
  end

endmodule
